// File: rtl/muldiv_pkg.sv
`default_nettype none
//==============================================================================
// muldiv_pkg : shared types and helpers for the iterative multiply/divide unit
// Revision   : 1.0
//==============================================================================
package muldiv_pkg;

   typedef enum logic [2:0] {
      OP_MUL    = 3'b000,
      OP_MULH   = 3'b001,
      OP_MULHSU = 3'b010,
      OP_MULHU  = 3'b011,
      OP_DIV    = 3'b100,
      OP_DIVU   = 3'b101,
      OP_REM    = 3'b110,
      OP_REMU   = 3'b111
   } muldiv_op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2,
      S_DONE = 2'd3
   } muldiv_state_e;

   localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

   function automatic logic op_is_div(input muldiv_op_e op);
      return op[2];
   endfunction

   // MUL low bits are sign-agnostic, so it is treated as fully unsigned.
   function automatic logic op_a_signed(input muldiv_op_e op);
      return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
   endfunction

   function automatic logic op_b_signed(input muldiv_op_e op);
      return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
   endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_sign_fix.sv
`default_nettype none
//==============================================================================
// muldiv_sign_fix : sign correction and half select applied to the raw result
// Revision        : 1.0
//==============================================================================
module muldiv_sign_fix
   import muldiv_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  muldiv_op_e          op,
   input  logic                neg_res,
   input  logic                neg_rem,
   input  logic [2*XLEN-1:0]   acc,
   output logic [XLEN-1:0]     result
);

   logic [2*XLEN-1:0] prod;
   logic [XLEN-1:0]   quot;
   logic [XLEN-1:0]   rem;

   // Divide leaves the remainder in the upper half and the quotient in the lower.
   always_comb begin
      prod = neg_res ? -acc : acc;
      quot = neg_res ? -acc[XLEN-1:0] : acc[XLEN-1:0];
      rem  = neg_rem ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
      case (op)
         OP_MUL:                        result = prod[XLEN-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU:  result = prod[2*XLEN-1:XLEN];
         OP_DIV, OP_DIVU:               result = quot;
         default:                       result = rem;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
//==============================================================================
// muldiv_unit : iterative RV32M/RV64M multiply/divide execute unit
// Revision    : 1.0
//==============================================================================
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int CNT_W = $clog2(XLEN)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] rs1,
   input  logic [XLEN-1:0] rs2,
   input  logic            kill,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result
);

   localparam logic [XLEN-1:0]  MIN_INT  = {1'b1, {(XLEN-1){1'b0}}};
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN-1);

   muldiv_state_e     state, state_nxt;
   muldiv_op_e        op;
   logic              sign_a, sign_b;
   logic [XLEN-1:0]   mag_a, mag_b;
   logic [2*XLEN-1:0] acc;
   logic [CNT_W-1:0]  cnt;

   muldiv_op_e        op_in;
   logic              a_neg_in, b_neg_in;
   logic [XLEN-1:0]   mag_a_in, mag_b_in;
   logic              div_by_zero, div_ovf, corner;
   logic [XLEN-1:0]   corner_res;
   logic              accept, cnt_last;

   logic [XLEN:0]     mul_sum;
   logic [2*XLEN-1:0] mul_next;
   logic [XLEN:0]     div_shift, div_diff;
   logic [2*XLEN-1:0] div_next;
   logic [XLEN-1:0]   fix_result;
   logic              neg_res;

   // Request decode: magnitudes, signs and the two divide short-cuts.
   always_comb begin
      op_in       = muldiv_op_e'(funct3);
      a_neg_in    = op_a_signed(op_in) & rs1[XLEN-1];
      b_neg_in    = op_b_signed(op_in) & rs2[XLEN-1];
      mag_a_in    = a_neg_in ? -rs1 : rs1;
      mag_b_in    = b_neg_in ? -rs2 : rs2;
      div_by_zero = op_is_div(op_in) && (rs2 == '0);
      div_ovf     = ((op_in == OP_DIV) || (op_in == OP_REM)) && (rs1 == MIN_INT) && (rs2 == '1);
      corner      = div_by_zero || div_ovf;
      if (div_by_zero)
         corner_res = op_in[1] ? rs1 : '1;
      else
         corner_res = (op_in == OP_DIV) ? MIN_INT : '0;
   end

   assign accept   = (state == S_IDLE) && in_valid && !kill;
   assign cnt_last = (cnt == CNT_LAST);

   // One iteration step for each algorithm; the carry/borrow bit is kept explicitly.
   always_comb begin
      mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, mag_a};
      mul_next  = acc[0] ? {mul_sum, acc[XLEN-1:1]} : {1'b0, acc[2*XLEN-1:1]};
      div_shift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
      div_diff  = div_shift - {1'b0, mag_b};
      div_next  = div_diff[XLEN] ? {div_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                                 : {div_diff[XLEN-1:0],  acc[XLEN-2:0], 1'b1};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= S_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (kill)
         state_nxt = S_IDLE;
      else begin
         case (state)
            S_IDLE: if (in_valid) state_nxt = corner ? S_DONE : S_CALC;
            S_CALC: if (cnt_last) state_nxt = S_FIX;
            S_FIX:  state_nxt = S_DONE;
            S_DONE: if (out_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
         endcase
      end
   end

   always_comb begin
      in_ready  = (state == S_IDLE);
      out_valid = (state == S_DONE);
   end

   // A kill freezes the datapath; result keeps its last written value.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op     <= OP_MUL;
         sign_a <= 1'b0;
         sign_b <= 1'b0;
         mag_a  <= '0;
         mag_b  <= '0;
         acc    <= '0;
         cnt    <= '0;
         result <= '0;
      end else if (accept) begin
         op     <= op_in;
         sign_a <= a_neg_in;
         sign_b <= b_neg_in;
         mag_a  <= mag_a_in;
         mag_b  <= mag_b_in;
         acc    <= {{XLEN{1'b0}}, (op_is_div(op_in) ? mag_a_in : mag_b_in)};
         cnt    <= '0;
         if (corner)
            result <= corner_res;
      end else if (!kill) begin
         case (state)
            S_CALC: begin
               acc <= op_is_div(op) ? div_next : mul_next;
               cnt <= cnt_last ? '0 : cnt + 1'b1;
            end
            S_FIX:   result <= fix_result;
            default: ;
         endcase
      end
   end

   assign neg_res = sign_a ^ sign_b;

   muldiv_sign_fix #(
      .XLEN    (XLEN)
   ) u_sign_fix (
      .op      (op),
      .neg_res (neg_res),
      .neg_rem (sign_a),
      .acc     (acc),
      .result  (fix_result)
   );

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
//==============================================================================
// tb_muldiv_unit : directed + randomized checks of muldiv_unit at XLEN 32 and 64
// Revision       : 1.0
//==============================================================================
module tb_muldiv_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        iv32, kl32, ordy32, ir32, ov32;
   logic [2:0]  f32;
   logic [31:0] a32, b32, res32;
   logic        iv64, ir64, ov64;
   logic [2:0]  f64;
   logic [63:0] a64, b64, res64;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   muldiv_unit #(.XLEN(32)) dut32 (
      .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32), .funct3(f32),
      .rs1(a32), .rs2(b32), .kill(kl32), .out_valid(ov32), .out_ready(ordy32),
      .result(res32)
   );

   muldiv_unit #(.XLEN(64)) dut64 (
      .clk(clk), .rst(rst), .in_valid(iv64), .in_ready(ir64), .funct3(f64),
      .rs1(a64), .rs2(b64), .kill(1'b0), .out_valid(ov64), .out_ready(1'b1),
      .result(res64)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: exact integer arithmetic on wide signed values, truncated to xl bits.
   function automatic logic [63:0] ref_model(input int xl, input logic [2:0] f,
                                             input logic [63:0] a, input logic [63:0] b);
      logic signed [129:0] ua, ub, sa, sb, r;
      logic [63:0] mask;
      mask = (xl == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
      ua = 130'(a & mask);
      ub = 130'(b & mask);
      sa = a[xl-1] ? ua - (130'sd1 <<< xl) : ua;
      sb = b[xl-1] ? ub - (130'sd1 <<< xl) : ub;
      case (f)
         3'd0: r = sa * sb;
         3'd1: r = (sa * sb) >>> xl;
         3'd2: r = (sa * ub) >>> xl;
         3'd3: r = (ua * ub) >>> xl;
         3'd4: r = (ub == 0) ? -130'sd1 : sa / sb;
         3'd5: r = (ub == 0) ? -130'sd1 : ua / ub;
         3'd6: r = (ub == 0) ? ua : sa % sb;
         default: r = (ub == 0) ? ua : ua % ub;
      endcase
      return 64'(r) & mask;
   endfunction

   function automatic logic [63:0] pick(input int xl);
      logic [63:0] mask;
      mask = (xl == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
      case ($urandom_range(0, 5))
         0: return 64'd0;
         1: return 64'd1 << (xl - 1);
         2: return mask;
         3: return 64'($urandom_range(0, 20));
         default: return {$urandom, $urandom} & mask;
      endcase
   endfunction

   function automatic logic get_ov(input int w);
      return (w == 32) ? ov32 : ov64;
   endfunction

   function automatic logic get_ir(input int w);
      return (w == 32) ? ir32 : ir64;
   endfunction

   function automatic logic [63:0] get_res(input int w);
      return (w == 32) ? {32'd0, res32} : res64;
   endfunction

   // Issue one op with out_ready high; check latency, result and the return to IDLE.
   task automatic issue(input int w, input logic [2:0] f, input logic [63:0] a,
                        input logic [63:0] b, input string tag);
      logic [63:0] exp, mask, minv;
      logic corner;
      int cyc;
      mask   = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
      minv   = 64'd1 << (w - 1);
      exp    = ref_model(w, f, a, b);
      corner = f[2] && (((b & mask) == 0) ||
                        (!f[0] && ((a & mask) == minv) && ((b & mask) == mask)));
      @(negedge clk);
      check({tag, " in_ready_before"}, 64'(get_ir(w)), 64'd1);
      if (w == 32) begin
         iv32 = 1'b1; f32 = f; a32 = a[31:0]; b32 = b[31:0];
      end else begin
         iv64 = 1'b1; f64 = f; a64 = a; b64 = b;
      end
      @(posedge clk); #1;
      iv32 = 1'b0; iv64 = 1'b0;
      a32 = $urandom; b32 = $urandom; a64 = {$urandom, $urandom}; b64 = {$urandom, $urandom};
      cyc = 1;
      while (!get_ov(w) && cyc < 200) begin
         @(posedge clk); #1;
         cyc++;
      end
      check({tag, " latency"}, 64'(cyc), corner ? 64'd1 : 64'(w + 2));
      check({tag, " result"}, get_res(w), exp);
      check({tag, " in_ready_done"}, 64'(get_ir(w)), 64'd0);
      @(posedge clk); #1;
      check({tag, " back_to_idle"}, {62'd0, get_ir(w), get_ov(w)}, 64'd2);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      logic seen;
      rst = 1'b1; iv32 = 1'b0; kl32 = 1'b0; ordy32 = 1'b1; f32 = '0; a32 = '0; b32 = '0;
      iv64 = 1'b0; f64 = '0; a64 = '0; b64 = '0;
      #3;
      check("reset32", {ir32, ov32, 30'd0, res32}, 64'h8000_0000_0000_0000);
      check("reset64_res", res64, 64'd0);
      check("reset64_hs", {62'd0, ir64, ov64}, 64'd2);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // A request under kill in IDLE must not be accepted.
      @(negedge clk);
      iv32 = 1'b1; f32 = 3'd0; a32 = 32'd3; b32 = 32'd5; kl32 = 1'b1;
      @(posedge clk); #1;
      iv32 = 1'b0; kl32 = 1'b0;
      check("kill_idle", {62'd0, ir32, ov32}, 64'd2);

      issue(32, 3'd0, 64'd7, 64'hFFFF_FFFD, "mul");
      issue(32, 3'd1, 64'h8000_0000, 64'h8000_0000, "mulh");
      issue(32, 3'd2, 64'h8000_0000, 64'h8000_0000, "mulhsu");
      issue(32, 3'd3, 64'h8000_0000, 64'h8000_0000, "mulhu");
      issue(32, 3'd4, 64'hFFFF_FFF9, 64'd2, "div");
      issue(32, 3'd6, 64'hFFFF_FFF9, 64'd2, "rem");
      issue(32, 3'd5, 64'd100, 64'd7, "divu");
      issue(32, 3'd7, 64'd100, 64'd7, "remu");
      issue(32, 3'd5, 64'($urandom), 64'd0, "divu_by0");
      issue(32, 3'd6, 64'h1234_5678, 64'd0, "rem_by0");
      issue(32, 3'd4, 64'h8000_0000, 64'hFFFF_FFFF, "div_ovf");
      issue(32, 3'd6, 64'h8000_0000, 64'hFFFF_FFFF, "rem_ovf");

      // Backpressure: result held in DONE, new requests ignored.
      ordy32 = 1'b0;
      @(negedge clk);
      iv32 = 1'b1; f32 = 3'd5; a32 = 32'd100; b32 = 32'd7;
      @(posedge clk); #1;
      iv32 = 1'b0;
      for (int i = 0; i < 200 && !ov32; i++) begin
         @(posedge clk); #1;
      end
      check("bp_result", {32'd0, res32}, 64'd14);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         iv32 = 1'b1; f32 = 3'($urandom); a32 = $urandom; b32 = $urandom;
         @(posedge clk); #1;
         check("bp_hold", {ir32, ov32, 30'd0, res32}, 64'h4000_0000_0000_000E);
      end
      @(negedge clk);
      iv32 = 1'b0; ordy32 = 1'b1;
      @(posedge clk); #1;
      check("bp_release", {62'd0, ir32, ov32}, 64'd2);
      @(posedge clk); #1;
      check("bp_no_ghost", {62'd0, ir32, ov32}, 64'd2);

      // Kill during CALC: back to IDLE, no result, result register untouched.
      @(negedge clk);
      iv32 = 1'b1; f32 = 3'd0; a32 = $urandom; b32 = $urandom;
      @(posedge clk); #1;
      iv32 = 1'b0;
      repeat (9) @(posedge clk);
      @(negedge clk);
      kl32 = 1'b1;
      @(posedge clk); #1;
      kl32 = 1'b0;
      check("kill_calc", {ir32, ov32, 30'd0, res32}, 64'h8000_0000_0000_000E);
      seen = 1'b0;
      repeat (40) begin
         @(posedge clk); #1;
         seen = seen | ov32;
      end
      check("kill_no_valid", 64'(seen), 64'd0);
      issue(32, 3'd0, 64'd3, 64'd5, "mul_after_kill");

      // Reset mid-CALC acts asynchronously.
      @(negedge clk);
      iv32 = 1'b1; f32 = 3'd4; a32 = $urandom; b32 = 32'd3;
      @(posedge clk); #1;
      iv32 = 1'b0;
      repeat (5) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("rst_async", {ir32, ov32, 30'd0, res32}, 64'h8000_0000_0000_0000);
      @(negedge clk);
      rst = 1'b0;
      issue(32, 3'd7, 64'd100, 64'd7, "remu_after_rst");

      for (int i = 0; i < 24; i++)
         issue(32, 3'($urandom), pick(32), pick(32), $sformatf("rnd32_%0d", i));

      issue(64, 3'd0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, "mul64");
      issue(64, 3'd1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, "mulh64");
      issue(64, 3'd4, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, "div64");
      issue(64, 3'd6, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, "rem64");
      issue(64, 3'd4, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, "div64_ovf");
      for (int i = 0; i < 8; i++)
         issue(64, 3'($urandom), pick(64), pick(64), $sformatf("rnd64_%0d", i));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
